// File: rtl/icb_pkg.sv
// Shared definitions for the SRAM ICB arbiter slice: bus width defaults,
// owner encoding and arbiter FSM state encoding.
package icb_pkg;

  localparam int unsigned AW_DEF = 32;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } own_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/icb_rr_pick.sv
// Two-request picker for the SRAM ICB arbiter.
// Build option: ICB_ARB_FIXED_PRI_EN selects fixed priority (request 0 always
// wins a tie); without it, a tie goes to the requester that did not win last.
module icb_rr_pick (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_gnt,
  output logic       o_any
);

`ifdef ICB_ARB_FIXED_PRI_EN
  logic w_unused_last;
  assign w_unused_last = i_last;

  // Fixed priority: requester 0 wins whenever it is asking.
  always_comb begin
    o_any = |i_req;
    o_gnt = ~i_req[0];
  end
`else
  // Round-robin: on a tie, grant the requester that was not granted last.
  always_comb begin
    o_any = |i_req;
    if (i_req == 2'b11) begin
      o_gnt = ~i_last;
    end else begin
      o_gnt = i_req[1] & ~i_req[0];
    end
  end
`endif

endmodule

// File: rtl/sram_icb_arb.sv
// Two-master to one-slave ICB arbiter in front of the SRAM ICB slave.
// One outstanding transaction; read responses are routed to the owner, write
// responses are generated locally because the SRAM only answers reads.
// Build option: ICB_ARB_FIXED_PRI_EN (fixed priority, m0 wins ties).
module sram_icb_arb
  import icb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            m0_icb_cmd_valid,
  output logic            m0_icb_cmd_ready,
  input  logic [AW-1:0]   m0_icb_cmd_addr,
  input  logic            m0_icb_cmd_read,
  input  logic [DW-1:0]   m0_icb_cmd_wdata,
  input  logic [DW/8-1:0] m0_icb_cmd_wmask,
  output logic            m0_icb_rsp_valid,
  input  logic            m0_icb_rsp_ready,
  output logic            m0_icb_rsp_err,
  output logic [DW-1:0]   m0_icb_rsp_rdata,

  input  logic            m1_icb_cmd_valid,
  output logic            m1_icb_cmd_ready,
  input  logic [AW-1:0]   m1_icb_cmd_addr,
  input  logic            m1_icb_cmd_read,
  input  logic [DW-1:0]   m1_icb_cmd_wdata,
  input  logic [DW/8-1:0] m1_icb_cmd_wmask,
  output logic            m1_icb_rsp_valid,
  input  logic            m1_icb_rsp_ready,
  output logic            m1_icb_rsp_err,
  output logic [DW-1:0]   m1_icb_rsp_rdata,

  output logic            s_icb_cmd_valid,
  input  logic            s_icb_cmd_ready,
  output logic [AW-1:0]   s_icb_cmd_addr,
  output logic            s_icb_cmd_read,
  output logic [DW-1:0]   s_icb_cmd_wdata,
  output logic [DW/8-1:0] s_icb_cmd_wmask,
  input  logic            s_icb_rsp_valid,
  output logic            s_icb_rsp_ready,
  input  logic            s_icb_rsp_err,
  input  logic [DW-1:0]   s_icb_rsp_rdata
);

  state_e          r_state;
  own_e            r_owner;
  own_e            r_last;
  logic            r_is_read;
  logic [AW-1:0]   r_addr;

  logic [1:0]      w_req;
  logic            w_gnt;
  logic            w_any;
  logic [AW-1:0]   w_cmd_addr;
  logic            w_cmd_read;
  logic [DW-1:0]   w_cmd_wdata;
  logic [DW/8-1:0] w_cmd_wmask;
  logic            w_own_rsp_valid;
  logic            w_own_rsp_ready;
  logic            w_rsp_err;
  logic [DW-1:0]   w_rsp_rdata;
  logic            w_cmd_hsk;
  logic            w_rsp_hsk;

  assign w_req = {m1_icb_cmd_valid, m0_icb_cmd_valid};

  icb_rr_pick u_pick (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_any  (w_any)
  );

  // Command fields of the currently granted master.
  always_comb begin
    w_cmd_addr  = w_gnt ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    w_cmd_read  = w_gnt ? m1_icb_cmd_read  : m0_icb_cmd_read;
    w_cmd_wdata = w_gnt ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    w_cmd_wmask = w_gnt ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
  end

  // Output steering; everything is forced to zero while reset is held so a
  // pending response is dropped immediately rather than one edge later.
  always_comb begin
    m0_icb_cmd_ready = 1'b0;
    m1_icb_cmd_ready = 1'b0;
    m0_icb_rsp_valid = 1'b0;
    m1_icb_rsp_valid = 1'b0;
    m0_icb_rsp_err   = 1'b0;
    m1_icb_rsp_err   = 1'b0;
    m0_icb_rsp_rdata = '0;
    m1_icb_rsp_rdata = '0;
    s_icb_cmd_valid  = 1'b0;
    s_icb_cmd_addr   = '0;
    s_icb_cmd_read   = 1'b0;
    s_icb_cmd_wdata  = '0;
    s_icb_cmd_wmask  = '0;
    s_icb_rsp_ready  = 1'b0;
    w_own_rsp_valid  = 1'b0;
    w_rsp_err        = 1'b0;
    w_rsp_rdata      = '0;
    w_own_rsp_ready  = (r_owner == OWN_M1) ? m1_icb_rsp_ready : m0_icb_rsp_ready;
    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          s_icb_cmd_valid = w_any;
          s_icb_cmd_addr  = w_cmd_addr;
          s_icb_cmd_read  = w_cmd_read;
          s_icb_cmd_wdata = w_cmd_wdata;
          s_icb_cmd_wmask = w_cmd_wmask;
          if (w_any) begin
            if (w_gnt) begin
              m1_icb_cmd_ready = s_icb_cmd_ready;
            end else begin
              m0_icb_cmd_ready = s_icb_cmd_ready;
            end
          end
        end
        S_WAIT: begin
          // Slave computes rsp_err from the live address, so keep it driven.
          s_icb_cmd_addr = r_addr;
          s_icb_cmd_read = r_is_read;
          if (r_is_read) begin
            w_own_rsp_valid = s_icb_rsp_valid;
            w_rsp_err       = s_icb_rsp_err;
            w_rsp_rdata     = s_icb_rsp_rdata;
            s_icb_rsp_ready = w_own_rsp_ready;
          end else begin
            w_own_rsp_valid = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (r_owner == OWN_M1) begin
      m1_icb_rsp_valid = w_own_rsp_valid;
      m1_icb_rsp_err   = w_rsp_err;
      m1_icb_rsp_rdata = w_rsp_rdata;
    end else begin
      m0_icb_rsp_valid = w_own_rsp_valid;
      m0_icb_rsp_err   = w_rsp_err;
      m0_icb_rsp_rdata = w_rsp_rdata;
    end
  end

  assign w_cmd_hsk = s_icb_cmd_valid & s_icb_cmd_ready;
  assign w_rsp_hsk = w_own_rsp_valid & w_own_rsp_ready;

  // Arbiter FSM: latch ownership on command handshake, release on response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_owner   <= OWN_M0;
      r_last    <= OWN_M1;
      r_is_read <= 1'b0;
      r_addr    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_hsk) begin
            r_owner   <= own_e'(w_gnt);
            r_last    <= own_e'(w_gnt);
            r_is_read <= w_cmd_read;
            r_addr    <= w_cmd_addr;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_rsp_hsk) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_icb_arb.sv
// Directed bench for sram_icb_arb with a small 1-cycle SRAM slave model
// (256-byte array; addresses at or above it answer with err=1, rdata=0).
module tb_sram_icb_arb;

  logic        clk;
  logic        rst_n;

  logic        m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
  logic [31:0] m0_icb_cmd_addr, m0_icb_cmd_wdata;
  logic [3:0]  m0_icb_cmd_wmask;
  logic        m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
  logic [31:0] m0_icb_rsp_rdata;

  logic        m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
  logic [31:0] m1_icb_cmd_addr, m1_icb_cmd_wdata;
  logic [3:0]  m1_icb_cmd_wmask;
  logic        m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
  logic [31:0] m1_icb_rsp_rdata;

  logic        s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
  logic [31:0] s_icb_cmd_addr, s_icb_cmd_wdata;
  logic [3:0]  s_icb_cmd_wmask;
  logic        s_icb_rsp_valid, s_icb_rsp_ready, s_icb_rsp_err;
  logic [31:0] s_icb_rsp_rdata;

  // SRAM model state
  logic [31:0] mem [64];
  logic        sv;
  logic        spur;
  logic        s_rdy;
  logic [31:0] srd;

  int unsigned n_chk;
  int unsigned n_pass;

  sram_icb_arb #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
    .m0_icb_cmd_addr(m0_icb_cmd_addr), .m0_icb_cmd_read(m0_icb_cmd_read),
    .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
    .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
    .m0_icb_rsp_err(m0_icb_rsp_err), .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
    .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
    .m1_icb_cmd_addr(m1_icb_cmd_addr), .m1_icb_cmd_read(m1_icb_cmd_read),
    .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
    .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
    .m1_icb_rsp_err(m1_icb_rsp_err), .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
    .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
    .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
    .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
    .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
    .s_icb_rsp_err(s_icb_rsp_err), .s_icb_rsp_rdata(s_icb_rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM slave model: writes land immediately, reads answer one cycle later
  // and hold until accepted; err follows the live command address.
  assign s_icb_cmd_ready = s_rdy;
  assign s_icb_rsp_valid = sv | spur;
  assign s_icb_rsp_rdata = srd;
  assign s_icb_rsp_err   = sv && (s_icb_cmd_addr >= 32'd256);

  always @(posedge clk) begin
    if (!rst_n) begin
      sv  <= 1'b0;
      srd <= '0;
    end else if (s_icb_cmd_valid && s_icb_cmd_ready) begin
      if (s_icb_cmd_read) begin
        sv  <= 1'b1;
        srd <= (s_icb_cmd_addr < 32'd256) ? mem[s_icb_cmd_addr[7:2]] : 32'h0;
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (s_icb_cmd_wmask[b]) mem[s_icb_cmd_addr[7:2]][8*b +: 8] <= s_icb_cmd_wdata[8*b +: 8];
        end
      end
    end else if (sv && s_icb_rsp_ready) begin
      sv <= 1'b0;
    end
  end

  // Per-master views for the table loop
  logic [1:0]  w_cready, w_rvalid, w_rerr;
  logic [31:0] w_rdata [2];
  assign w_cready   = {m1_icb_cmd_ready, m0_icb_cmd_ready};
  assign w_rvalid   = {m1_icb_rsp_valid, m0_icb_rsp_valid};
  assign w_rerr     = {m1_icb_rsp_err,   m0_icb_rsp_err};
  assign w_rdata[0] = m0_icb_rsp_rdata;
  assign w_rdata[1] = m1_icb_rsp_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input int m, input logic v, input logic rd, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] wm);
    if (m == 0) begin
      m0_icb_cmd_valid = v; m0_icb_cmd_read = rd; m0_icb_cmd_addr = a;
      m0_icb_cmd_wdata = wd; m0_icb_cmd_wmask = wm;
    end else begin
      m1_icb_cmd_valid = v; m1_icb_cmd_read = rd; m1_icb_cmd_addr = a;
      m1_icb_cmd_wdata = wd; m1_icb_cmd_wmask = wm;
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          mst;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0;
    tbl[0] = '{0, 1'b0, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[1] = '{0, 1'b1, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{0, 1'b0, 32'h0,   32'hA0A0A0A0, 4'hF, 32'h0,        1'b0};
    tbl[3] = '{1, 1'b0, 32'h4,   32'hB1B1B1B1, 4'hF, 32'h0,        1'b0};
    tbl[4] = '{1, 1'b0, 32'h20,  32'h11223344, 4'hF, 32'h0,        1'b0};
    tbl[5] = '{0, 1'b0, 32'h20,  32'h0000AB00, 4'h2, 32'h0,        1'b0};
    tbl[6] = '{1, 1'b1, 32'h20,  32'h0,        4'h0, 32'h1122AB44, 1'b0};
    tbl[7] = '{0, 1'b1, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1};
    tbl[8] = '{1, 1'b1, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};

    rst_n = 1'b0; spur = 1'b0; s_rdy = 1'b1;
    drive(0, 1'b1, 1'b1, 32'h10, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    m0_icb_rsp_ready = 1'b1; m1_icb_rsp_ready = 1'b1;

    // Reset: valid request must not leak through while reset is held
    step(); step();
    #4;
    chk("rst_m0_cmd_ready", {31'b0, m0_icb_cmd_ready}, 32'd0);
    chk("rst_s_cmd_valid",  {31'b0, s_icb_cmd_valid},  32'd0);
    chk("rst_m0_rsp_valid", {31'b0, m0_icb_rsp_valid}, 32'd0);
    chk("rst_s_rsp_ready",  {31'b0, s_icb_rsp_ready},  32'd0);
    chk("rst_s_cmd_addr",   s_icb_cmd_addr,            32'd0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    rst_n = 1'b1;

    // Single-master transactions from the table
    for (int i = 0; i < 9; i++) begin
      int m;
      m = tbl[i].mst;
      drive(m, 1'b1, tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].wmask);
      #4;
      chk($sformatf("v%0d_cmd_ready", i),   {31'b0, w_cready[m]},   32'd1);
      chk($sformatf("v%0d_other_ready", i), {31'b0, w_cready[1-m]}, 32'd0);
      chk($sformatf("v%0d_s_valid", i),     {31'b0, s_icb_cmd_valid}, 32'd1);
      chk($sformatf("v%0d_s_addr", i),      s_icb_cmd_addr, tbl[i].addr);
      step();
      drive(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #4;
      chk($sformatf("v%0d_rsp_valid", i),   {31'b0, w_rvalid[m]},   32'd1);
      chk($sformatf("v%0d_other_rsp", i),   {31'b0, w_rvalid[1-m]}, 32'd0);
      chk($sformatf("v%0d_rsp_err", i),     {31'b0, w_rerr[m]},     {31'b0, tbl[i].exp_err});
      chk($sformatf("v%0d_rsp_rdata", i),   w_rdata[m],             tbl[i].exp_rdata);
      chk($sformatf("v%0d_wait_addr", i),   s_icb_cmd_addr,         tbl[i].addr);
      step();
    end

    // Both masters valid every cycle: grants alternate, starting with m0
    drive(0, 1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b1, 32'h4, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      int g;
      g = k % 2;
      #4;
      chk($sformatf("rr%0d_gnt_ready", k),  {31'b0, w_cready[g]},   32'd1);
      chk($sformatf("rr%0d_lose_ready", k), {31'b0, w_cready[1-g]}, 32'd0);
      step();
      #4;
      chk($sformatf("rr%0d_rsp_valid", k),  {31'b0, w_rvalid[g]},   32'd1);
      chk($sformatf("rr%0d_other_rsp", k),  {31'b0, w_rvalid[1-g]}, 32'd0);
      chk($sformatf("rr%0d_rdata", k),      w_rdata[g], (g == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1);
      step();
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // m1 read with rsp_ready held low; m0 waits behind it
    m1_icb_rsp_ready = 1'b0;
    drive(1, 1'b1, 1'b1, 32'h20, 32'h0, 4'h0);
    #4;
    chk("hold_m1_cmd_ready", {31'b0, m1_icb_cmd_ready}, 32'd1);
    step();
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(0, 1'b1, 1'b1, 32'h10, 32'h0, 4'h0);
    for (int k = 0; k < 5; k++) begin
      #4;
      chk($sformatf("hold%0d_rsp_valid", k), {31'b0, m1_icb_rsp_valid}, 32'd1);
      chk($sformatf("hold%0d_rdata", k),     m1_icb_rsp_rdata, 32'h1122AB44);
      chk($sformatf("hold%0d_m0_ready", k),  {31'b0, m0_icb_cmd_ready}, 32'd0);
      step();
    end
    m1_icb_rsp_ready = 1'b1;
    #4;
    chk("hold_rel_rsp_valid", {31'b0, m1_icb_rsp_valid}, 32'd1);
    chk("hold_rel_m0_ready",  {31'b0, m0_icb_cmd_ready}, 32'd0);
    step();
    #4;
    chk("hold_next_m0_ready", {31'b0, m0_icb_cmd_ready}, 32'd1);
    step();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #4;
    chk("hold_next_m0_rdata", m0_icb_rsp_rdata, 32'hDEADBEEF);
    step();

    // Spurious slave response in IDLE is ignored
    spur = 1'b1;
    #4;
    chk("spur_s_rsp_ready", {31'b0, s_icb_rsp_ready},  32'd0);
    chk("spur_m0_rsp",      {31'b0, m0_icb_rsp_valid}, 32'd0);
    chk("spur_m1_rsp",      {31'b0, m1_icb_rsp_valid}, 32'd0);
    step();
    spur = 1'b0;

    // m1 withdraws before handshake: last grant (m0) must stay unchanged
    s_rdy = 1'b0;
    drive(1, 1'b1, 1'b1, 32'h4, 32'h0, 4'h0);
    #4;
    chk("drop_s_valid",   {31'b0, s_icb_cmd_valid},  32'd1);
    chk("drop_m1_ready",  {31'b0, m1_icb_cmd_ready}, 32'd0);
    step();
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    s_rdy = 1'b1;
    step();
    drive(0, 1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b1, 32'h4, 32'h0, 4'h0);
    #4;
    chk("drop_m1_wins",  {31'b0, m1_icb_cmd_ready}, 32'd1);
    chk("drop_m0_loses", {31'b0, m0_icb_cmd_ready}, 32'd0);
    step();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #4;
    chk("drop_m1_rdata", m1_icb_rsp_rdata, 32'hB1B1B1B1);
    step();

    // Reset while waiting on an m0 read: outputs clear, m0 wins next tie
    m0_icb_rsp_ready = 1'b0;
    drive(0, 1'b1, 1'b1, 32'h10, 32'h0, 4'h0);
    step();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #4;
    chk("rw_pre_rsp_valid", {31'b0, m0_icb_rsp_valid}, 32'd1);
    step();
    rst_n = 1'b0;
    #4;
    chk("rw_rsp_valid", {31'b0, m0_icb_rsp_valid}, 32'd0);
    chk("rw_rsp_rdata", m0_icb_rsp_rdata,          32'd0);
    chk("rw_s_addr",    s_icb_cmd_addr,            32'd0);
    chk("rw_s_rready",  {31'b0, s_icb_rsp_ready},  32'd0);
    step();
    rst_n = 1'b1;
    m0_icb_rsp_ready = 1'b1;
    drive(0, 1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b1, 32'h4, 32'h0, 4'h0);
    #4;
    chk("rw_idle_m0_ready", {31'b0, m0_icb_cmd_ready}, 32'd1);
    chk("rw_idle_m1_ready", {31'b0, m1_icb_cmd_ready}, 32'd0);
    step();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #4;
    chk("rw_m0_rdata", m0_icb_rsp_rdata, 32'hA0A0A0A0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
